// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared types and defaults for the GPIO output controller
package gpio_pkg;
   typedef enum logic [1:0] {IDLE, STROBE, FALL} state_t;

   localparam int GPIO_W    = 8;
   localparam int IMG_BYTES = 152100;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two circular FIFO with registered full/empty
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             r_full;
   logic             r_empty;
   logic             w_push;
   logic             w_pop;
   logic [AW:0]      w_wptr_nxt;
   logic [AW:0]      w_rptr_nxt;

   assign w_push     = i_push && !r_full;
   assign w_pop      = i_pop && !r_empty;
   assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_push};
   assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};

   // Flags are computed from the next pointers so they are valid right after the edge.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_wptr  <= w_wptr_nxt;
         r_rptr  <= w_rptr_nxt;
         r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                    (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
         r_empty <= (w_wptr_nxt == w_rptr_nxt);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rptr[AW-1:0]];
   assign o_full  = r_full;
   assign o_empty = r_empty;
endmodule

// File: rtl/gpio_out_ctrl.sv
// rtl/gpio_out_ctrl.sv - buffered byte sequencer onto GPIO with strobe and frame counting
module gpio_out_ctrl
   import gpio_pkg::*;
#(
   parameter int DEPTH         = 16,
   parameter int STROBE_CYCLES = 2,
   parameter int FRAME_BYTES   = IMG_BYTES
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wr_en,
   input  logic [GPIO_W-1:0]                    wr_data,
   output logic                                 full,
   output logic                                 overflow,
   output logic [GPIO_W-1:0]                    GPIO,
   output logic                                 GPIOEn,
   output logic [$clog2(FRAME_BYTES+1)-1:0]     byte_count,
   output logic                                 frame_done
);
   localparam int CW = $clog2(FRAME_BYTES + 1);
   localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [SW-1:0]     r_cnt;
   logic [SW-1:0]     w_cnt_nxt;
   logic [GPIO_W-1:0] r_gpio;
   logic [GPIO_W-1:0] w_gpio_nxt;
   logic              r_en;
   logic              w_en_nxt;
   logic [CW-1:0]     r_bytes;
   logic [CW-1:0]     w_bytes_nxt;
   logic              r_fd;
   logic              w_fd_nxt;
   logic              r_ovf;
   logic              w_pop;
   logic [GPIO_W-1:0] w_fifo_data;
   logic              w_full;
   logic              w_empty;

   sync_fifo #(.WIDTH(GPIO_W), .DEPTH(DEPTH)) u_fifo (
      .i_clk   (clk),
      .i_rstn  (rst),
      .i_push  (wr_en),
      .i_data  (wr_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // The low cycle after a strobe doubles as an issue slot, giving one byte per STROBE_CYCLES+1.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gpio_nxt  = r_gpio;
      w_en_nxt    = r_en;
      w_bytes_nxt = r_bytes;
      w_fd_nxt    = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         IDLE, FALL: begin
            w_en_nxt    = 1'b0;
            w_state_nxt = IDLE;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_gpio_nxt  = w_fifo_data;
               w_en_nxt    = 1'b1;
               w_cnt_nxt   = SW'(STROBE_CYCLES - 1);
               w_state_nxt = STROBE;
            end
         end
         STROBE: begin
            if (r_cnt == '0) begin
               w_en_nxt    = 1'b0;
               w_state_nxt = FALL;
               if (r_bytes == CW'(FRAME_BYTES - 1)) begin
                  w_bytes_nxt = '0;
                  w_fd_nxt    = 1'b1;
               end else begin
                  w_bytes_nxt = r_bytes + CW'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt - SW'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_gpio  <= '0;
         r_en    <= 1'b0;
         r_bytes <= '0;
         r_fd    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gpio  <= w_gpio_nxt;
         r_en    <= w_en_nxt;
         r_bytes <= w_bytes_nxt;
         r_fd    <= w_fd_nxt;
         r_ovf   <= r_ovf | (wr_en & w_full);
      end
   end

   assign full       = w_full;
   assign overflow   = r_ovf;
   assign GPIO       = r_gpio;
   assign GPIOEn     = r_en;
   assign byte_count = r_bytes;
   assign frame_done = r_fd;
endmodule

// File: doc/gpio_out_ctrl.md
# gpio_out_ctrl

- Buffered output controller for the processor's 8-bit GPIO port.
- The core pushes bytes into a small FIFO, and the block sequences them onto `GPIO` with a fixed-width `GPIOEn` strobe. The external consumer samples `GPIO` on the falling edge of `GPIOEn`.
- Counts bytes per frame (default is one 390×390 image, 152100 bytes) and flags frame completion.
- Sits between the processor's store path and the `GPIO`/`GPIOEn` pins.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `STROBE_CYCLES`, 2: cycles `GPIOEn` stays high per byte; ≥1.
- `FRAME_BYTES`, 152100: bytes per frame; ≥1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `wr_en` in 1: push `wr_data`. Ignored while `full`.
- `wr_data` in 8: byte to output.
- `full` out 1: FIFO holds `DEPTH` entries (registered).
- `overflow` out 1: sticky; set when `wr_en` is asserted while `full`. Cleared only by reset.
- `GPIO` out 8: output byte; held stable from strobe rise through the cycle after strobe fall.
- `GPIOEn` out 1: output strobe.
- `byte_count` out `$clog2(FRAME_BYTES+1)`: bytes completed in the current frame.
- `frame_done` out 1: one-cycle pulse when the last byte of a frame completes.

## Operation

- FSM states:
  - `IDLE`: `GPIOEn`=0. If the FIFO is non-empty, pop the head, register it into `GPIO`, set `GPIOEn`=1, load the strobe counter with `STROBE_CYCLES`-1, and go to `STROBE`.
  - `STROBE`: `GPIOEn`=1. When the counter reaches 0, clear `GPIOEn` and go to `FALL`; otherwise decrement.
  - `FALL`: `GPIOEn`=0, `GPIO` unchanged. Increment `byte_count` and go to `IDLE`.
- Frame counting:
  - When `byte_count` would reach `FRAME_BYTES`, it wraps to 0 and `frame_done` pulses in that same `FALL` cycle.
  - `byte_count` never shows `FRAME_BYTES`.
- FIFO:
  - Push when `wr_en && !full`. Pop only from `IDLE`.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - No fall-through: a byte written into an empty FIFO is not visible to `IDLE` until the next cycle.
  - A write while `full` is dropped and sets `overflow`, even if a pop occurs in the same cycle, because `full` is registered.
- Reset (`rst`=0 at an edge) clears everything, including mid-strobe:
  - FIFO emptied.
  - `full`=0, `overflow`=0, `GPIO`=8'h00, `GPIOEn`=0, `byte_count`=0, `frame_done`=0.
  - FSM returns to `IDLE`.
  - No partial byte is counted.

## Timing

- All outputs are registered.
- Write latency: `wr_en` at edge k (FIFO empty, FSM in `IDLE`) → `GPIO`/`GPIOEn`=1 valid after edge k+1.
- `GPIOEn` is high for exactly `STROBE_CYCLES` cycles, then low for at least 1 cycle (`FALL`).
- Sustained throughput: one byte per `STROBE_CYCLES`+1 cycles. Default is 3 cycles per byte, so a full frame takes 456300 cycles.
- `GPIO` changes only on the edge that raises `GPIOEn`. It is therefore stable for the whole high phase and the following low cycle.
- `frame_done` is asserted in the `FALL` cycle of the final byte, coincident with `byte_count` returning to 0.
- `full` updates one edge after the push or pop that changes occupancy.

## Structure

- Package `gpio_pkg` holds:
  - the FSM state enum `{IDLE, STROBE, FALL}`;
  - default constants `GPIO_W`=8 and `IMG_BYTES`=152100.
- Sub-module `sync_fifo`:
  - parameterised width/depth; registered `full`/`empty`;
  - power-of-two circular buffer with extra-bit read/write pointers.
- Top-level `gpio_out_ctrl` contains the FSM, strobe counter, frame counter, and overflow flag.

## Test plan

- Single byte, defaults: write 8'hA5 at cycle 10 → `GPIOEn` high during cycles 11–12 with `GPIO`=A5; low at cycle 13; `byte_count`=1.
- Burst of 20 back-to-back writes, `DEPTH`=16, defaults:
  - `full` asserts.
  - Writes issued while `full` set `overflow`=1.
  - Exactly the accepted bytes appear in order, one strobe per 3 cycles.
- Frame wrap, `FRAME_BYTES`=4: write 9 bytes → `frame_done` pulses after bytes 4 and 8; final `byte_count`=1.
- Reset mid-strobe: assert `rst`=0 during `STROBE` with 5 bytes queued → next edge `GPIOEn`=0, `GPIO`=00, counters 0; no further strobes without new writes.
- `STROBE_CYCLES`=1 with continuous writes → `GPIOEn` toggles 1,0,1,0; each falling edge carries the next byte in order; no drops while not `full`.
- Simultaneous push/pop at full occupancy: write while `full` in the same cycle as `IDLE` pops → write dropped and `overflow` set; occupancy goes to `DEPTH`-1.
